// File: rtl/btn_debounce.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state FSM with registered level, press and release outputs.
// Optional auto-repeat of btn_tick while the button is held is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce #(
    parameter int unsigned STABLE_TICKS = 1000000,
    parameter int unsigned REPEAT_TICKS = 50000000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_tick,
    output logic btn_rel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 32'd1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 32'd1);
`endif

    // Reject parameter values the counter cannot represent.
    if ((STABLE_TICKS < 32'd2) || (64'(STABLE_TICKS) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_stable
        $error("btn_debounce: STABLE_TICKS out of range");
    end
    if ((REPEAT_TICKS < 32'd2) || (64'(REPEAT_TICKS) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_TICKS out of range");
    end

    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             tick_q, tick_d;
    logic             rel_q, rel_d;

    // Next-state, counter and pulse computation; only the synchronized s1 drives decisions.
    always_comb begin
        s0_d    = btn_in;
        s1_d    = s0_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s1_q) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT1: begin
                if (!s1_q) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ONE;
                    cnt_d   = CNT_ZERO;
                    tick_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ONE: begin
                if (!s1_q) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_ZERO;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    tick_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
`else
                end else begin
                    state_d = ONE;
                    cnt_d   = CNT_ZERO;
                end
`endif
            end
            WAIT0: begin
                // A return to ONE restarts any repeat count from zero.
                if (s1_q) begin
                    state_d = ONE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        level_d = (state_d == ONE) || (state_d == WAIT0);
    end

    // State, synchronizer and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            tick_q  <= tick_d;
            rel_q   <= rel_d;
        end
    end

    assign btn_level = level_q;
    assign btn_tick  = tick_q;
    assign btn_rel   = rel_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized self-checking bench for btn_debounce against a run-length reference model.
// Define DEBOUNCE_AUTOREPEAT_EN for both bench and RTL to exercise the auto-repeat build.
module tb_btn_debounce;

    localparam int S = 4;
    localparam int R = 10;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level, btn_tick, btn_rel;

    always #5 clk = ~clk;

    btn_debounce #(
        .STABLE_TICKS(S),
        .REPEAT_TICKS(R),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_tick(btn_tick),
        .btn_rel(btn_rel)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the level flips once S+1 consecutive synchronized samples disagree with it.
    logic m_s0, m_s1, m_level, m_tick, m_rel;
    int   run, start, edge_n;
    bit   low;

    // Window statistics for directed scenarios.
    int step_n, tick_seen, rel_seen, lvl_hi, lvl_lo, tick_at, rel_at;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s0 = 1'b0; m_s1 = 1'b0; m_level = 1'b0; m_tick = 1'b0; m_rel = 1'b0;
        run = 0; start = 0; low = 1'b0;
    endtask

    task automatic model_edge(input logic din);
        logic x;
        x = m_s1;
        m_s1 = m_s0;
        m_s0 = din;
        m_tick = 1'b0;
        m_rel = 1'b0;
        edge_n++;
        if (x != m_level) run++;
        else run = 0;
        if (run == S + 1) begin
            m_level = x;
            run = 0;
            if (x) begin
                m_tick = 1'b1;
                start = edge_n;
                low = 1'b0;
            end else begin
                m_rel = 1'b1;
            end
        end else if (AUTO && m_level) begin
            if (!x) low = 1'b1;
            else if (low) begin
                low = 1'b0;
                start = edge_n;
            end else if (((edge_n - start) % R) == 0) begin
                m_tick = 1'b1;
            end
        end
    endtask

    task automatic mark();
        step_n = 0; tick_seen = 0; rel_seen = 0; lvl_hi = 0; lvl_lo = 0;
        tick_at = -1; rel_at = -1;
    endtask

    task automatic step(input logic v);
        btn_in = v;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(v);
        #1;
        check_val("level", 32'(btn_level), 32'(m_level));
        check_val("tick", 32'(btn_tick), 32'(m_tick));
        check_val("rel", 32'(btn_rel), 32'(m_rel));
        check_val("tick_rel_excl", 32'(btn_tick & btn_rel), 32'd0);
        if (btn_tick) begin tick_seen++; tick_at = step_n; end
        if (btn_rel) begin rel_seen++; rel_at = step_n; end
        if (btn_level) lvl_hi++;
        else lvl_lo++;
        step_n++;
    endtask

    task automatic apply_reset(input logic v);
        btn_in = v;
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_level", 32'(btn_level), 32'd0);
        check_val("rst_tick", 32'(btn_tick), 32'd0);
        check_val("rst_rel", 32'(btn_rel), 32'd0);
        model_reset();
        step(v);
        step(v);
        reset = 1'b0;
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        mark();
        reset = 1'b1;
        btn_in = 1'b0;
        #1;
        check_val("init_level", 32'(btn_level), 32'd0);
        check_val("init_tick", 32'(btn_tick), 32'd0);
        check_val("init_rel", 32'(btn_rel), 32'd0);
        repeat (3) step(1'b0);
        reset = 1'b0;
        repeat (5) step(1'b0);

        // Clean press: tick exactly 6 edges after the first high sample.
        mark();
        repeat (13) step(1'b1);
        check_val("press_tick_at", tick_at, 6);
        check_val("press_ticks", tick_seen, 1);
        check_val("press_lvl_hi", lvl_hi, 7);

        // Clean release.
        mark();
        repeat (12) step(1'b0);
        check_val("rel_at", rel_at, 6);
        check_val("rel_count", rel_seen, 1);
        check_val("rel_no_tick", tick_seen, 0);

        // Short 3-cycle pulse is rejected.
        mark();
        repeat (3) step(1'b1);
        repeat (12) step(1'b0);
        check_val("short_ticks", tick_seen, 0);
        check_val("short_rels", rel_seen, 0);
        check_val("short_lvl_hi", lvl_hi, 0);

        // 2-cycle low glitch during an accepted press.
        repeat (12) step(1'b1);
        mark();
        repeat (2) step(1'b0);
        repeat (6) step(1'b1);
        check_val("glitch_ticks", tick_seen, 0);
        check_val("glitch_rels", rel_seen, 0);
        check_val("glitch_lvl_lo", lvl_lo, 0);
        repeat (12) step(1'b0);

        // Reset while held in ONE, then a fresh press from the hold.
        repeat (10) step(1'b1);
        apply_reset(1'b1);
        mark();
        repeat (10) step(1'b1);
        check_val("post_rst_tick_at", tick_at, 6);
        check_val("post_rst_ticks", tick_seen, 1);
        repeat (12) step(1'b0);

        // Long hold: 40 cycles past acceptance.
        mark();
        repeat (47) step(1'b1);
        check_val("hold_ticks", tick_seen, AUTO ? 5 : 1);
        check_val("hold_first_tick", (tick_seen > 0) ? 1 : 0, 1);
        repeat (12) step(1'b0);

        // Random bursts with occasional resets.
        for (int b = 0; b < 200; b++) begin
            logic v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) apply_reset(v);
            for (int k = 0; k < len; k++) step(v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
- REQ-001: Parameter STABLE_TICKS, default 1000000: consecutive clk cycles the synchronized input must hold a new level before it is accepted (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
- REQ-002: Parameter REPEAT_TICKS, default 50000000: auto-repeat period in clk cycles; used only when DEBOUNCE_AUTOREPEAT_EN is defined; legal range 2..2^CNT_W-1.
- REQ-003: Parameter CNT_W, default 26: width of the internal cycle counter.
- REQ-004: clk  input  1  single clock; all state changes on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: btn_in  input  1  raw push-button level, asynchronous to clk, may bounce.
- REQ-007: btn_level  output  1  debounced, registered button level.
- REQ-008: btn_tick  output  1  one-cycle press pulse; feeds the stopwatch push_reset and push_add5 inputs.
- REQ-009: btn_rel  output  1  one-cycle release pulse.

Function
- REQ-010: btn_in SHALL pass through a two-flop synchronizer (s0, s1); only s1 drives the FSM.
- REQ-011: FSM states SHALL be IDLE, WAIT1, ONE and WAIT0, encoded in 2 bits.
- REQ-012: IDLE: s1=1 -> WAIT1, counter cleared to 0; otherwise stay in IDLE.
- REQ-013: WAIT1: s1=0 -> IDLE (bounce rejected); s1=1 with counter=STABLE_TICKS-1 -> ONE; otherwise counter+1.
- REQ-014: ONE: s1=0 -> WAIT0, counter cleared to 0; otherwise stay in ONE.
- REQ-015: WAIT0: s1=1 -> ONE (bounce rejected, no pulse); s1=0 with counter=STABLE_TICKS-1 -> IDLE; otherwise counter+1.
- REQ-016: btn_level SHALL be 1 exactly while the state is ONE or WAIT0.
- REQ-017: btn_tick SHALL be registered and high for exactly one cycle, in the cycle after the WAIT1->ONE transition edge.
- REQ-018: btn_rel SHALL be registered and high for exactly one cycle, in the cycle after the WAIT0->IDLE transition edge.
- REQ-019: Press latency: btn_in high and stable from before edge E0 -> btn_level and btn_tick high starting at edge E0+STABLE_TICKS+2.
- REQ-020: Any bounce shorter than STABLE_TICKS cycles SHALL produce no pulse and no btn_level change.
- REQ-021: btn_tick and btn_rel SHALL never be high in the same cycle.
- REQ-022: The counter SHALL never exceed STABLE_TICKS-1 in the WAIT states; it never wraps.

Reset
- REQ-023: On reset assertion, asynchronously: s0=s1=0, state=IDLE, counter=0, btn_level=0, btn_tick=0, btn_rel=0.
- REQ-024: Reset asserted mid-WAIT1 or mid-ONE SHALL cancel the operation with no pulse.
- REQ-025: After reset deasserts with btn_in held high, the block SHALL treat the hold as a new press and emit one btn_tick per REQ-019.

Configuration
- REQ-026: Macro DEBOUNCE_AUTOREPEAT_EN defined: in ONE, counter increments each cycle; at counter=REPEAT_TICKS-1 it clears to 0 and btn_tick pulses one cycle; the first repeat occurs REPEAT_TICKS cycles after entry to ONE.
- REQ-027: Macro DEBOUNCE_AUTOREPEAT_EN defined: entering WAIT0 clears the counter; a return to ONE restarts the repeat count from 0.
- REQ-028: Macro DEBOUNCE_AUTOREPEAT_EN undefined: exactly one btn_tick per accepted press; no repeat logic is synthesized.

Verification (bench: STABLE_TICKS=4, REPEAT_TICKS=10)
- REQ-029: btn_in 0->1 at E0, held -> btn_tick=1 only in the cycle after edge E0+6; btn_level=1 from that edge on.
- REQ-030: btn_in pulses high 3 cycles, then low -> btn_tick, btn_level and btn_rel stay 0 throughout.
- REQ-031: Accepted press, then a 2-cycle low glitch, then high -> btn_level stays 1, no extra btn_tick, no btn_rel.
- REQ-032: Accepted press, release held low -> btn_rel=1 for one cycle 6 edges after the fall; btn_level=0 from that edge.
- REQ-033: reset pulsed while in ONE with btn_in still high -> outputs 0 immediately; one new btn_tick 6 edges after reset release.
- REQ-034: DEBOUNCE_AUTOREPEAT_EN defined, btn_in held 40 cycles after acceptance -> initial btn_tick plus repeats every 10 cycles (4 repeats); macro undefined -> a single btn_tick.
